// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the data-bus responder: queued request record,
// access-size encodings and the issue FSM state type.
package dbus_responder_pkg;

    localparam logic [2:0] DBUS_SIZE_BYTE = 3'd0;
    localparam logic [2:0] DBUS_SIZE_HALF = 3'd1;
    localparam logic [2:0] DBUS_SIZE_WORD = 3'd2;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dbus_req_t;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_REQ  = 1'b1
    } iss_state_t;

endpackage

// File: rtl/dbus_req_queue.sv
// In-order request storage with allocate / issue / return pointers. Pointers carry
// one extra MSB so a full queue (count == DEPTH) is distinguishable from empty.
module dbus_req_queue
    import dbus_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_en,
    input  dbus_req_t       alloc_data,
    input  logic            iss_en,
    input  logic            ret_en,
    input  logic [PW-1:0]   rd_ptr,
    output dbus_req_t       rd_data,
    input  logic [PW-1:0]   rsp_ptr,
    output logic            rsp_wr,
    output logic [PW-1:0]   alloc_ptr,
    output logic [PW-1:0]   iss_ptr,
    output logic [PW-1:0]   ret_ptr,
    output logic [PW-1:0]   count
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    dbus_req_t entries [DEPTH];

    // Storage needs no reset: an entry is only read after it has been allocated.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            entries[alloc_ptr[IW-1:0]] <= alloc_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr <= '0;
            iss_ptr   <= '0;
            ret_ptr   <= '0;
        end else begin
            if (alloc_en) alloc_ptr <= alloc_ptr + PTR_ONE;
            if (iss_en)   iss_ptr   <= iss_ptr + PTR_ONE;
            if (ret_en)   ret_ptr   <= ret_ptr + PTR_ONE;
        end
    end

    assign count   = alloc_ptr - ret_ptr;
    assign rd_data = entries[rd_ptr[IW-1:0]];
    assign rsp_wr  = entries[rsp_ptr[IW-1:0]].wr;

endmodule

// File: rtl/dbus_responder.sv
// Responder for the execute stage's data bus: queues up to DEPTH requests, issues
// them in order on a grant/valid memory port and returns one data_ok per request.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcache_req,
    input  logic        dcache_wr,
    input  logic [3:0]  dcache_wstrb,
    input  logic [2:0]  dcache_size,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    output logic        dcache_addr_ok,
    output logic        dcache_data_ok,
    output logic [31:0] dcache_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH) + 1;

    iss_state_t    state;
    dbus_req_t     new_req, nxt_req, sel_req;
    logic [PW-1:0] alloc_ptr, iss_ptr, ret_ptr, count, nxt_ptr, rsp_ptr;
    logic          accept, iss_adv, load_slot, nxt_stored;
    logic          in_flight, rsp_ok, rsp_is_store;

    assign accept         = dcache_req && !reset && (count < PW'(DEPTH));
    assign dcache_addr_ok = accept;

    assign new_req = '{wr:    dcache_wr,
                       wstrb: dcache_wr ? dcache_wstrb : 4'b0000,
                       addr:  {dcache_addr[31:2], 2'b00},
                       wdata: dcache_wdata};

    // A new entry is loaded when idle or when the current one is granted. If the next
    // entry is being accepted this very cycle it is taken straight from the inputs.
    assign iss_adv    = (state == ISS_REQ) && mem_gnt;
    assign load_slot  = (state == ISS_IDLE) || mem_gnt;
    assign nxt_ptr    = iss_ptr + PW'(iss_adv);
    assign nxt_stored = nxt_ptr != alloc_ptr;
    assign sel_req    = nxt_stored ? nxt_req : new_req;

    // ret_ptr only moves while data_ok is high, so a response already registered
    // but not yet retired shifts the entry that the current rvalid belongs to.
    assign rsp_ptr   = ret_ptr + PW'(dcache_data_ok);
    assign in_flight = iss_ptr != rsp_ptr;
    assign rsp_ok    = mem_rvalid && in_flight;

    dbus_req_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (accept),
        .alloc_data (new_req),
        .iss_en     (iss_adv),
        .ret_en     (dcache_data_ok),
        .rd_ptr     (nxt_ptr),
        .rd_data    (nxt_req),
        .rsp_ptr    (rsp_ptr),
        .rsp_wr     (rsp_is_store),
        .alloc_ptr  (alloc_ptr),
        .iss_ptr    (iss_ptr),
        .ret_ptr    (ret_ptr),
        .count      (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ISS_IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load_slot) begin
            if (nxt_stored || accept) begin
                state     <= ISS_REQ;
                mem_req   <= 1'b1;
                mem_wr    <= sel_req.wr;
                mem_wstrb <= sel_req.wstrb;
                mem_addr  <= sel_req.addr;
                mem_wdata <= sel_req.wdata;
            end else begin
                state   <= ISS_IDLE;
                mem_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcache_data_ok <= 1'b0;
            dcache_rdata   <= '0;
        end else begin
            dcache_data_ok <= rsp_ok;
            dcache_rdata   <= (rsp_ok && !rsp_is_store) ? mem_rdata : '0;
        end
    end

    // A completion with nothing outstanding is dropped above; flag it here.
    a_rvalid_in_flight: assert property (@(posedge clk) disable iff (reset)
        mem_rvalid |-> in_flight);
    a_size_legal: assert property (@(posedge clk) disable iff (reset)
        dcache_req |-> dcache_size <= DBUS_SIZE_WORD);
    a_byte_store_lane: assert property (@(posedge clk) disable iff (reset)
        (dcache_req && dcache_wr && dcache_size == DBUS_SIZE_BYTE)
        |-> dcache_wstrb == (4'b0001 << dcache_addr[1:0]));

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: directed latency/full/stall/reset scenarios plus random
// traffic, scored against a word-memory reference model updated in acceptance order.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    logic        clk, reset;
    logic        dcache_req, dcache_wr;
    logic [3:0]  dcache_wstrb;
    logic [2:0]  dcache_size;
    logic [31:0] dcache_addr, dcache_wdata;
    logic        dcache_addr_ok, dcache_data_ok;
    logic [31:0] dcache_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    dbus_responder #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_wstrb(dcache_wstrb),
        .dcache_size(dcache_size), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok),
        .dcache_rdata(dcache_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [31:0] rdata;
        int unsigned ready;
    } fly_t;

    logic [31:0] exp_q[$];
    dbus_req_t   iss_exp[$];
    fly_t        inflight[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bench_mem[logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_pct = 100, rv_pct = 100, rv_dly_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
    endfunction

    function automatic logic [31:0] bench_rd(input logic [31:0] w);
        return bench_mem.exists(w) ? bench_mem[w] : mem_init(w);
    endfunction

    task automatic preload(input logic [31:0] w, input logic [31:0] v);
        ref_mem[w]   = v;
        bench_mem[w] = v;
    endtask

    // Reference model: every accepted request is applied to ref_mem in order.
    logic [31:0] acc_w;
    dbus_req_t   acc_e;
    always @(negedge clk) begin
        if (!reset && dcache_req && dcache_addr_ok) begin
            acc_w = {dcache_addr[31:2], 2'b00};
            acc_e = '{wr: dcache_wr, wstrb: dcache_wr ? dcache_wstrb : 4'b0000,
                      addr: acc_w, wdata: dcache_wdata};
            if (dcache_wr) begin
                ref_mem[acc_w] = merge(ref_rd(acc_w), dcache_wdata, dcache_wstrb);
                exp_q.push_back(32'h0);
            end else begin
                exp_q.push_back(ref_rd(acc_w));
            end
            iss_exp.push_back(acc_e);
        end
    end

    // Memory side: checks each grant and stability while stalled, then queues the completion.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_wdata, prev_ctl;
    dbus_req_t   g_e;
    logic [31:0] g_rd;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_req",   {31'b0, mem_req}, 32'h1);
                check("stall_addr",  mem_addr, prev_addr);
                check("stall_ctl",   {27'b0, mem_wr, mem_wstrb}, prev_ctl);
                check("stall_wdata", mem_wdata, prev_wdata);
            end
            if (mem_req && mem_gnt) begin
                if (iss_exp.size() == 0) begin
                    fail("grant_unexpected");
                end else begin
                    g_e = iss_exp.pop_front();
                    check("grant_addr", mem_addr, g_e.addr);
                    check("grant_ctl", {27'b0, mem_wr, mem_wstrb}, {27'b0, g_e.wr, g_e.wstrb});
                    if (g_e.wr) check("grant_wdata", mem_wdata, g_e.wdata);
                end
                if (mem_wr) begin
                    bench_mem[mem_addr] = merge(bench_rd(mem_addr), mem_wdata, mem_wstrb);
                    g_rd = $urandom | 32'h1;
                end else begin
                    g_rd = bench_rd(mem_addr);
                end
                inflight.push_back('{rdata: g_rd,
                                     ready: cyc + 1 + $urandom_range(0, rv_dly_max)});
            end
            prev_hold  = mem_req && !mem_gnt;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_ctl   = {27'b0, mem_wr, mem_wstrb};
        end
    end

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                inflight.delete();
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end else begin
                mem_gnt = ($urandom_range(0, 99) < gnt_pct);
                if (inflight.size() > 0 && cyc >= inflight[0].ready &&
                    $urandom_range(0, 99) < rv_pct) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = inflight[0].rdata;
                    void'(inflight.pop_front());
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                end
            end
        end
    end

    // Response monitor.
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (!reset && dcache_data_ok) begin
            if (exp_q.size() == 0) begin
                fail("data_ok_unexpected");
            end else begin
                mon_exp = exp_q.pop_front();
                check("rdata", dcache_rdata, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [31:0] a, input logic [3:0] st,
                           input logic [31:0] wd, input logic [2:0] sz);
        dcache_req = 1'b1; dcache_wr = wr; dcache_addr = a;
        dcache_wstrb = st; dcache_wdata = wd; dcache_size = sz;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 1000; k++) begin
            if (exp_q.size() == 0 && iss_exp.size() == 0 && inflight.size() == 0 &&
                !mem_req && !dcache_data_ok) break;
            next_cycle();
        end
        if (k == 1000) fail("drain_timeout");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr_ok"}, {31'b0, dcache_addr_ok}, 32'h0);
        check({tag, "_data_ok"}, {31'b0, dcache_data_ok}, 32'h0);
        check({tag, "_rdata"},   dcache_rdata, 32'h0);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
        check({tag, "_mem_ctl"}, {27'b0, mem_wr, mem_wstrb}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] snap_addr, snap_wdata;
    logic [31:0] r_addr;
    logic [3:0]  r_st;
    logic [2:0]  r_sz;
    logic        r_wr, ok;
    int          dok_at, acc_at, k;

    initial begin
        reset = 1'b1;
        dcache_req = 1'b0; dcache_wr = 1'b0; dcache_wstrb = '0; dcache_size = '0;
        dcache_addr = '0; dcache_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        dcache_req = 1'b1;
        #1;
        check_outputs_zero("reset");
        dcache_req = 1'b0;
        reset = 1'b0;
        next_cycle();

        // Single load: accept c0, mem_req c1, rvalid c2, data_ok c3.
        preload(32'h1000_0004, 32'hDEAD_BEEF);
        set_req(1'b0, 32'h1000_0004, 4'b0000, 32'h0, DBUS_SIZE_WORD);
        @(negedge clk); check("t1_addr_ok", {31'b0, dcache_addr_ok}, 32'h1);
        next_cycle(); dcache_req = 1'b0;
        @(negedge clk);
        check("t1_mem_req", {31'b0, mem_req}, 32'h1);
        check("t1_mem_addr", mem_addr, 32'h1000_0004);
        check("t1_mem_wr", {31'b0, mem_wr}, 32'h0);
        next_cycle(); @(negedge clk); check("t1_dok_c2", {31'b0, dcache_data_ok}, 32'h0);
        next_cycle(); @(negedge clk); check("t1_dok_c3", {31'b0, dcache_data_ok}, 32'h1);
        wait_idle();

        // Byte store at a misaligned byte address.
        set_req(1'b1, 32'h2000_0003, 4'b1000, 32'hAB00_0000, DBUS_SIZE_BYTE);
        next_cycle(); dcache_req = 1'b0;
        @(negedge clk);
        check("t2_mem_addr", mem_addr, 32'h2000_0000);
        check("t2_mem_ctl", {27'b0, mem_wr, mem_wstrb}, {27'b0, 1'b1, 4'b1000});
        check("t2_mem_wdata", mem_wdata, 32'hAB00_0000);
        wait_idle();

        // Full queue: third load waits until the cycle after the first data_ok.
        gnt_pct = 0;
        set_req(1'b0, 32'h0000_0200, 4'b0, 32'h0, DBUS_SIZE_WORD);
        @(negedge clk); check("t3_acc_a", {31'b0, dcache_addr_ok}, 32'h1);
        next_cycle(); dcache_addr = 32'h0000_0204;
        @(negedge clk); check("t3_acc_b", {31'b0, dcache_addr_ok}, 32'h1);
        next_cycle(); dcache_addr = 32'h0000_0208;
        @(negedge clk); check("t3_full_c2", {31'b0, dcache_addr_ok}, 32'h0);
        next_cycle();
        @(negedge clk); check("t3_full_c3", {31'b0, dcache_addr_ok}, 32'h0);
        gnt_pct = 100;
        dok_at = -1; acc_at = -1;
        for (k = 0; k < 50; k++) begin
            next_cycle();
            @(negedge clk);
            if (dcache_data_ok && dok_at < 0) dok_at = k;
            if (dcache_addr_ok) begin
                acc_at = k;
                break;
            end
        end
        check("t3_accept_after_dok", acc_at, dok_at + 1);
        check("t3_dok_seen", {31'b0, dok_at >= 0}, 32'h1);
        next_cycle(); dcache_req = 1'b0;
        wait_idle();

        // Grant delayed 5 cycles: fields stable c1..c6, second entry issues c7.
        gnt_pct = 0;
        set_req(1'b0, 32'h0000_0A00, 4'b0, 32'h0, DBUS_SIZE_WORD);
        next_cycle();
        set_req(1'b1, 32'h0000_0A0C, 4'b1111, 32'h1234_5678, DBUS_SIZE_WORD);
        @(negedge clk);
        check("t4_req_c1", {31'b0, mem_req}, 32'h1);
        check("t4_addr_c1", mem_addr, 32'h0000_0A00);
        snap_addr = mem_addr; snap_wdata = mem_wdata;
        next_cycle(); dcache_req = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check("t4_hold_addr", mem_addr, snap_addr);
            check("t4_hold_wdata", mem_wdata, snap_wdata);
            if (c == 5) gnt_pct = 100;
            next_cycle();
        end
        @(negedge clk);
        check("t4_next_req", {31'b0, mem_req}, 32'h1);
        check("t4_next_addr", mem_addr, 32'h0000_0A0C);
        wait_idle();

        // Load then store with back-to-back completions.
        preload(32'h0000_0100, 32'h1111_1111);
        set_req(1'b0, 32'h0000_0100, 4'b0, 32'h0, DBUS_SIZE_WORD);
        next_cycle();
        set_req(1'b1, 32'h0000_0104, 4'b1111, 32'h2222_2222, DBUS_SIZE_WORD);
        next_cycle(); dcache_req = 1'b0;
        @(negedge clk); check("t5_dok_c2", {31'b0, dcache_data_ok}, 32'h0);
        next_cycle(); @(negedge clk); check("t5_dok_c3", {31'b0, dcache_data_ok}, 32'h1);
        next_cycle(); @(negedge clk); check("t5_dok_c4", {31'b0, dcache_data_ok}, 32'h1);
        wait_idle();

        // Reset with two requests outstanding.
        gnt_pct = 0;
        set_req(1'b1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, DBUS_SIZE_WORD);
        next_cycle();
        set_req(1'b0, 32'h0000_0304, 4'b0, 32'h0, DBUS_SIZE_WORD);
        next_cycle();
        dcache_addr = 32'h0000_0308;
        reset = 1'b1;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete(); iss_exp.delete(); inflight.delete();
        ref_mem.delete(); bench_mem.delete();
        next_cycle();
        reset = 1'b0; dcache_req = 1'b0;
        gnt_pct = 100;
        next_cycle();
        set_req(1'b0, 32'h0000_0308, 4'b0, 32'h0, DBUS_SIZE_WORD);
        @(negedge clk); check("rst_acc", {31'b0, dcache_addr_ok}, 32'h1);
        next_cycle(); dcache_req = 1'b0;
        @(negedge clk); check("rst_dok_c1", {31'b0, dcache_data_ok}, 32'h0);
        next_cycle(); @(negedge clk); check("rst_dok_c2", {31'b0, dcache_data_ok}, 32'h0);
        next_cycle(); @(negedge clk); check("rst_dok_c3", {31'b0, dcache_data_ok}, 32'h1);
        wait_idle();

        // Random traffic over a small address window.
        gnt_pct = 60; rv_pct = 60; rv_dly_max = 3;
        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin gnt_pct = 95; rv_pct = 95; rv_dly_max = 0; end
            r_wr   = 1'($urandom_range(0, 1));
            r_sz   = 3'($urandom_range(0, 2));
            r_addr = 32'h0000_4000 + 32'($urandom_range(0, 63));
            if (r_sz == DBUS_SIZE_HALF) r_addr[0] = 1'b0;
            if (r_sz == DBUS_SIZE_WORD) r_addr[1:0] = 2'b00;
            case (r_sz)
                DBUS_SIZE_BYTE: r_st = 4'b0001 << r_addr[1:0];
                DBUS_SIZE_HALF: r_st = r_addr[1] ? 4'b1100 : 4'b0011;
                default:        r_st = 4'b1111;
            endcase
            set_req(r_wr, r_addr, r_wr ? r_st : 4'b0000, $urandom, r_sz);
            k = 0;
            do begin
                @(negedge clk);
                ok = dcache_addr_ok;
                next_cycle();
                k++;
            end while (!ok && k < 200);
            if (!ok) fail("accept_timeout");
            if ($urandom_range(0, 3) == 0) begin
                dcache_req = 1'b0;
                repeat ($urandom_range(1, 3)) next_cycle();
            end
        end
        dcache_req = 1'b0;
        wait_idle();
        check("final_exp_empty", exp_q.size(), 32'h0);
        check("final_iss_empty", iss_exp.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        fail("watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
